// File: rtl/train_tour_bfs.sv
// rtl/train_tour_bfs.sv - shortest-hop route engine: streamed track list, level-synchronous BFS
// Builds an adjacency matrix from a frame, then expands one BFS level per cycle until the goal or an empty frontier.
module train_tour_bfs #(
  parameter int N_STATION = 16,
  parameter int ST_W      = $clog2(N_STATION),
  parameter int COST_W    = ST_W + 1,
  parameter bit DIRECTED  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [ST_W-1:0]   source,
  input  logic [ST_W-1:0]   destination,
  output logic              out_valid,
  output logic [COST_W-1:0] cost
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEARCH,
    S_OUT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [N_STATION-1:0][N_STATION-1:0] adj;
  logic [N_STATION-1:0] frontier;
  logic [N_STATION-1:0] visited;
  logic [N_STATION-1:0] reach;
  logic [N_STATION-1:0] next_front;
  logic [ST_W-1:0]      start_st;
  logic [ST_W-1:0]      goal_st;
  logic [COST_W-1:0]    level;
  logic                 goal_hit;
  logic                 front_empty;

  // One BFS step: union of neighbours of every frontier station, minus anything already seen.
  always_comb begin
    reach = '0;
    for (int i = 0; i < N_STATION; i++) begin
      if (frontier[i]) begin
        reach = reach | adj[i];
      end
    end
    next_front  = reach & ~visited;
    goal_hit    = frontier[goal_st];
    front_empty = (frontier == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (in_valid) state_nxt = S_LOAD;
      S_LOAD:   if (!in_valid) state_nxt = S_SEARCH;
      S_SEARCH: if (goal_hit || front_empty) state_nxt = S_OUT;
      S_OUT:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Inputs are only consumed while in_valid is high, so don't-care values never reach state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adj       <= '0;
      frontier  <= '0;
      visited   <= '0;
      level     <= '0;
      start_st  <= '0;
      goal_st   <= '0;
      out_valid <= 1'b0;
      cost      <= '0;
    end else begin
      out_valid <= 1'b0;
      cost      <= '0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            start_st <= source;
            goal_st  <= destination;
            adj      <= '0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (source != destination) begin
              adj[source][destination] <= 1'b1;
              if (!DIRECTED) begin
                adj[destination][source] <= 1'b1;
              end
            end
          end else begin
            frontier <= N_STATION'(1) << start_st;
            visited  <= N_STATION'(1) << start_st;
            level    <= '0;
          end
        end
        S_SEARCH: begin
          if (goal_hit) begin
            out_valid <= 1'b1;
            cost      <= level;
          end else if (front_empty) begin
            out_valid <= 1'b1;
            cost      <= '1;
          end else begin
            frontier <= next_front;
            visited  <= visited | next_front;
            level    <= level + COST_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_train_tour_bfs.sv
// tb/tb_train_tour_bfs.sv - scoreboard bench for train_tour_bfs
// Three instances: default undirected, directed, and 64-station; expectations queued as frames are driven.
module tb_train_tour_bfs;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       iv0, iv1, iv2;
  logic [3:0] src0, dst0, src1, dst1;
  logic [5:0] src2, dst2;
  logic       ov0, ov1, ov2;
  logic [4:0] cost0, cost1;
  logic [6:0] cost2;

  train_tour_bfs u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .source(src0), .destination(dst0),
    .out_valid(ov0), .cost(cost0)
  );

  train_tour_bfs #(.DIRECTED(1'b1)) u_dut_dir (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .source(src1), .destination(dst1),
    .out_valid(ov1), .cost(cost1)
  );

  train_tour_bfs #(.N_STATION(64), .COST_W(7)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .source(src2), .destination(dst2),
    .out_valid(ov2), .cost(cost2)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int sel;
    int cost;
    int cyc;
  } sb_t;

  sb_t sb_q[$];
  int  es[$];
  int  ed[$];

  function automatic logic ov_of(input int sel);
    case (sel)
      0:       return ov0;
      1:       return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic int cost_of(input int sel);
    case (sel)
      0:       return int'(cost0);
      1:       return int'(cost1);
      default: return int'(cost2);
    endcase
  endfunction

  task automatic set_in(input int sel, input logic v, input int s, input int d);
    case (sel)
      0: begin iv0 = v; src0 = 4'(s); dst0 = 4'(d); end
      1: begin iv1 = v; src1 = 4'(s); dst1 = 4'(d); end
      default: begin iv2 = v; src2 = 6'(s); dst2 = 6'(d); end
    endcase
  endtask

  task automatic add_edge(input int s, input int d);
    es.push_back(s);
    ed.push_back(d);
  endtask

  task automatic clear_edges();
    es.delete();
    ed.delete();
  endtask

  // Streams header + edge list; d_lat is the search depth before out_valid (cost, or eccentricity+1).
  task automatic run_frame(input int sel, input int st, input int gl, input int ecost,
                           input int d_lat, input int gap, input bit expect_out);
    sb_t e;
    bit  seen;
    repeat (gap) @(posedge clk);
    @(posedge clk); #1;
    set_in(sel, 1'b1, st, gl);
    for (int i = 0; i < es.size(); i++) begin
      @(posedge clk); #1;
      set_in(sel, 1'b1, es[i], ed[i]);
    end
    @(posedge clk); #1;
    set_in(sel, 1'b0, int'($urandom), int'($urandom));
    if (!expect_out) return;
    e.sel  = sel;
    e.cost = ecost;
    e.cyc  = cyc + 2 + d_lat;
    sb_q.push_back(e);
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (ov_of(sel)) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("timeout_out_valid", 0, 1);
  endtask

  logic [2:0] ov_prev = '0;

  always @(negedge clk) begin
    sb_t e;
    for (int s = 0; s < 3; s++) begin
      if (ov_prev[s]) begin
        check("pulse_width", ov_of(s), 0);
        check("cost_idle_zero", cost_of(s), 0);
      end
      if (ov_of(s)) begin
        if (sb_q.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("sel", s, e.sel);
          check("cost", cost_of(s), e.cost);
          check("latency", cyc, e.cyc);
        end
      end
    end
    ov_prev <= {ov2, ov1, ov0};
  end

  initial begin
    set_in(0, 1'b0, 0, 0);
    set_in(1, 1'b0, 0, 0);
    set_in(2, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ov0", ov0, 0);
    check("rst_ov1", ov1, 0);
    check("rst_ov2", ov2, 0);
    check("rst_cost0", cost0, 0);
    check("rst_cost1", cost1, 0);
    check("rst_cost2", cost2, 0);
    @(negedge clk) rst_n = 1'b1;

    // 16-station undirected chain and corner cases
    clear_edges();
    for (int i = 0; i < 15; i++) add_edge(i, i + 1);
    run_frame(0, 0, 15, 15, 15, 0, 1'b1);
    clear_edges();
    add_edge(3, 4); add_edge(4, 5);
    run_frame(0, 3, 3, 0, 0, 0, 1'b1);
    clear_edges();
    add_edge(0, 1); add_edge(1, 2); add_edge(5, 9);
    run_frame(0, 0, 9, 31, 3, 1, 1'b1);
    clear_edges();
    run_frame(0, 2, 5, 31, 1, 0, 1'b1);
    clear_edges();
    add_edge(15, 14); add_edge(14, 13);
    run_frame(0, 13, 15, 2, 2, 2, 1'b1);

    // directed mode
    clear_edges();
    add_edge(2, 1); add_edge(1, 0); add_edge(0, 2);
    run_frame(1, 0, 2, 1, 1, 0, 1'b1);
    run_frame(1, 2, 0, 2, 2, 0, 1'b1);
    run_frame(1, 1, 2, 2, 2, 0, 1'b1);
    run_frame(1, 0, 3, 31, 3, 0, 1'b1);

    // 64-station star with duplicates and self-loops, zero and random gaps
    clear_edges();
    for (int k = 1; k < 64; k++) add_edge(0, k);
    add_edge(5, 0); add_edge(0, 5); add_edge(7, 7); add_edge(0, 0); add_edge(42, 0);
    for (int f = 0; f < 6; f++) begin
      int g;
      g = (f < 3) ? 0 : int'($urandom_range(1, 4));
      case (f % 3)
        0: run_frame(2, 17, 42, 2, 2, g, 1'b1);
        1: run_frame(2, 0, 63, 1, 1, g, 1'b1);
        default: run_frame(2, 5, 5, 0, 0, g, 1'b1);
      endcase
    end

    // reset mid-SEARCH aborts the frame
    clear_edges();
    for (int i = 0; i < 15; i++) add_edge(i, i + 1);
    run_frame(0, 0, 15, 0, 0, 0, 1'b0);
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_ov", ov0, 0);
    check("abort_cost", cost0, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (25) @(posedge clk);
    check("abort_no_pending", sb_q.size(), 0);
    clear_edges();
    add_edge(1, 0);
    run_frame(0, 0, 1, 1, 1, 0, 1'b1);

    repeat (4) @(posedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/train_tour_bfs.md
# train_tour_bfs

Parametrised shortest-hop route engine for the Train Tour design. A host streams a start/goal station pair followed by a track (edge) list over `in_valid`. The block builds an adjacency matrix, runs a level-synchronous breadth-first search, and returns the minimum hop count on `cost` with a one-cycle `out_valid` pulse. It generalises the fixed 16-station, 4-bit engine: station count, cost width and directed/undirected track mode are configurable, the start and goal stations are runtime inputs, and unreachable goals are reported explicitly.

## Interface
- `N_STATION`, 16: number of stations; must be a power of two, range 4–64.
- `ST_W`, $clog2(N_STATION): station index width.
- `COST_W`, ST_W+1: cost width; must be ≥ ST_W+1.
- `DIRECTED`, 0: 0 means every edge is bidirectional; 1 means an edge is source→destination only.

- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  high while a frame is being streamed; contiguous within a frame.
- `source`  in  ST_W  first frame cycle: start station; later cycles: edge tail.
- `destination`  in  ST_W  first frame cycle: goal station; later cycles: edge head.
- `out_valid`  out  1  result strobe; high for exactly one cycle per frame.
- `cost`  out  COST_W  hop count while `out_valid`=1; 0 otherwise.

## Operation
- FSM has four states: IDLE, LOAD, SEARCH, OUT.
- IDLE:
  - When `in_valid`=1 is sampled, latch start←`source` and goal←`destination`.
  - Clear the full N×N adjacency matrix, then go to LOAD.
  - That first cycle carries no edge.
- LOAD, while `in_valid`=1, each cycle sets adj[`source`][`destination`].
  - When DIRECTED=0, it also sets adj[`destination`][`source`].
  - Self-loops (`source`==`destination`) are ignored.
  - Duplicate edges are idempotent.
  - A frame with zero edges is legal.
- LOAD with `in_valid`=0 sampled: go to SEARCH with frontier={start}, visited={start}, level=0.
- SEARCH evaluates one level per cycle:
  - If goal ∈ frontier: result=level, go to OUT.
  - Else if frontier is empty: result=all-ones (2^COST_W−1, "unreachable"), go to OUT.
  - Otherwise:
    - next = OR of adj rows of all frontier stations, masked by ~visited.
    - frontier←next, visited|=next, level←level+1.
- OUT: `out_valid`=1 and `cost`=result for one cycle, then return to IDLE.
- Level never exceeds N_STATION−1. No saturation logic is needed beyond the width rule on COST_W.
- Protocol obligations on the host:
  - `in_valid` is not reasserted until the cycle after `out_valid`.
  - If `in_valid` rises during SEARCH or OUT, it is ignored and the frame is lost. The bench never does this.
- `source`/`destination` are don't-care while `in_valid`=0. X on these inputs must not propagate into state.

## Timing
- Reset (asynchronous assert; synchronous deassert handled upstream):
  - `out_valid`=0, `cost`=0, FSM=IDLE.
  - Adjacency, frontier, visited and level are cleared.
- A reset asserted mid-LOAD or mid-SEARCH aborts the frame: no `out_valid`, and the block is ready for a new frame.
- Outputs are registered. `cost` is forced to 0 whenever `out_valid`=0.
- Latency: let E0 be the first rising edge sampling `in_valid`=0 after LOAD.
  - `out_valid` rises at edge E0+1+d.
  - d = cost for a reachable goal.
  - d = (eccentricity of start)+1 for an unreachable goal.
- Start==goal: `out_valid` at E0+1, `cost`=0.
- Worst case: `out_valid` at E0+N_STATION.
- Throughput: a new frame's `in_valid` may rise at the edge following the `out_valid` cycle.

## Test plan
- Default params; start=0, goal=15; chain 0-1, 1-2, …, 14-15 streamed in order → `cost`=15, `out_valid` at E0+16, high for exactly 1 cycle.
- Default params; start=3, goal=3; edges 3-4, 4-5 → `cost`=0 at E0+1.
- Default params; start=0, goal=9; edges 0-1, 1-2, 5-9 → `cost`=31 (unreachable), `out_valid` at E0+4.
- DIRECTED=1; start=0, goal=2; edges 2→1, 1→0, 0→2 → `cost`=1. The same edges with start=2, goal=0 → `cost`=2.
- N_STATION=64, COST_W=7; star 0-k for k=1..63 plus duplicate and self-loop edges; start=17, goal=42 → `cost`=2. Check back-to-back frames with zero gap and with a 1–4 cycle random gap.
- Reset pulse mid-SEARCH of a 15-hop frame:
  - Outputs go to 0 immediately, and no `out_valid` appears.
  - The next frame (start=0, goal=1, edge 1-0) returns `cost`=1.
